// File: rtl/alu_print_pkg.sv
// Purpose: shared types and constants for the ALU operand loader and printer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_print_pkg;

  // Loader sequence: three nibble loads, one issue cycle, optional hold.
  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    LOAD_C = 3'd2,
    ISSUE  = 3'd3,
    HOLD   = 3'd4
  } ld_state_t;

  localparam int ALUC_W_DEF = 4;  // default ALU control width
  localparam int CMD_CNT_W  = 8;  // issued-command counter width

endpackage

// File: rtl/hold_timer.sv
// Purpose: down-counter that times a fixed hold window after a start pulse.
// Latency: done is high CYCLES cycles after start (start at CYCLES-1, done when 0).
// Backpressure: none; start restarts the count at any time.
//
// Ports:
//   clk, rst_n : clock, async active-low reset (counter resets to 0)
//   start      : load CYCLES-1 on the next edge
//   done       : counter reads 0
module hold_timer #(
  parameter int CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic done
);

  localparam int CW = (CYCLES < 1) ? 1 : $clog2(CYCLES + 1);
  // CYCLES=0 never starts the timer in practice; load 0 so the width stays sane.
  localparam logic [CW-1:0] LOAD_VAL = (CYCLES < 1) ? '0 : CW'(CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/alu_operand_loader.sv
// Purpose: gathers A, B, ALU-control nibbles and presents them as a held, registered command.
// Latency: command visible on the third accept edge; issue lasts 1 cycle; then HOLD_CYCLES hold.
// Backpressure: nib_ready is low during ISSUE/HOLD; the source keeps its nibble until ready.
//
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   clr                  : sync clear, drops a partial load, outputs untouched
//   nib_in/nib_valid     : input nibble stream; nib_ready = in a LOAD state
//   ops_out, aluc_out    : registered {op1, op2} and ALU control
//   issue, busy          : state decodes (ISSUE; ISSUE or HOLD)
//   cmd_count            : commands issued, wraps
module alu_operand_loader
  import alu_print_pkg::*;
#(
  parameter int W           = 4,
  parameter int ALUC_W      = ALUC_W_DEF,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic [W-1:0]         nib_in,
  input  logic                 nib_valid,
  output logic                 nib_ready,
  output logic [2*W-1:0]       ops_out,
  output logic [ALUC_W-1:0]    aluc_out,
  output logic                 issue,
  output logic                 busy,
  output logic [CMD_CNT_W-1:0] cmd_count
);

  ld_state_t      state_q, state_d;
  logic [W-1:0]   sh_a, sh_b;
  logic           accept;
  logic           hold_start, hold_done;

  // Ready/issue/busy decode the state register only; no input reaches them.
  assign nib_ready = (state_q == LOAD_A) || (state_q == LOAD_B) || (state_q == LOAD_C);
  assign issue     = (state_q == ISSUE);
  assign busy      = (state_q == ISSUE) || (state_q == HOLD);
  assign accept    = nib_valid && nib_ready;

  // Timer is armed on the edge leaving ISSUE, i.e. on entry to HOLD.
  assign hold_start = (state_q == ISSUE) && !clr;

  hold_timer #(.CYCLES(HOLD_CYCLES)) u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .start (hold_start),
    .done  (hold_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD_A:  if (accept) state_d = LOAD_B;
      LOAD_B:  if (accept) state_d = LOAD_C;
      LOAD_C:  if (accept) state_d = ISSUE;
      ISSUE:   state_d = (HOLD_CYCLES == 0) ? LOAD_A : HOLD;
      HOLD:    if (hold_done) state_d = LOAD_A;
      default: state_d = LOAD_A;
    endcase
    if (clr) state_d = LOAD_A;
  end

  // The third nibble goes straight into aluc_out on its accept edge, so it
  // needs no shadow of its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOAD_A;
      sh_a      <= '0;
      sh_b      <= '0;
      ops_out   <= '0;
      aluc_out  <= '0;
      cmd_count <= '0;
    end else begin
      state_q <= state_d;
      if (clr) begin
        sh_a <= '0;
        sh_b <= '0;
      end else if (accept) begin
        case (state_q)
          LOAD_A: sh_a <= nib_in;
          LOAD_B: sh_b <= nib_in;
          LOAD_C: begin
            ops_out  <= {sh_a, sh_b};
            aluc_out <= nib_in[ALUC_W-1:0];
          end
          default: ;
        endcase
      end
      if ((state_q == ISSUE) && !clr) cmd_count <= cmd_count + CMD_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_operand_loader.sv
module tb_alu_operand_loader;

  typedef struct packed {
    logic [7:0] ops;
    logic [3:0] aluc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, clr, nib_valid;
  logic [3:0] nib_in;
  logic       nib_ready, issue, busy;
  logic [7:0] ops_out, cmd_count;
  logic [3:0] aluc_out;

  // Second instance with no hold window, fed a constant stream.
  logic       clr0 = 1'b0, valid0 = 1'b1;
  logic [3:0] nib0 = 4'h9;
  logic       ready0, issue0, busy0;
  logic [7:0] ops0, cnt0;
  logic [3:0] aluc0;

  always #5 clk = ~clk;

  alu_operand_loader #(.W(4), .ALUC_W(4), .HOLD_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .nib_in(nib_in), .nib_valid(nib_valid),
    .nib_ready(nib_ready), .ops_out(ops_out), .aluc_out(aluc_out), .issue(issue),
    .busy(busy), .cmd_count(cmd_count));

  alu_operand_loader #(.W(4), .ALUC_W(4), .HOLD_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr0), .nib_in(nib0), .nib_valid(valid0),
    .nib_ready(ready0), .ops_out(ops0), .aluc_out(aluc0), .issue(issue0),
    .busy(busy0), .cmd_count(cnt0));

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: nibbles gathered since the last clear/issue; every third
  // one completes a command.
  logic [3:0] pend[$];
  exp_t       sbq[$];
  int         nmodel = 0;
  bit         contig = 0;
  bit         done0 = 0;

  // Offer one nibble (called at a negedge); returns at the negedge after it is taken.
  task automatic send(input logic [3:0] n, input bit with_clr);
    int w = 0;
    nib_in = n;
    nib_valid = 1'b1;
    while (!nib_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      chk("ready_timeout", 32'(w), 32'd0);
      nib_valid = 1'b0;
      return;
    end
    clr = with_clr;
    if (with_clr) pend.delete();
    else begin
      pend.push_back(n);
      if (pend.size() == 3) begin
        sbq.push_back('{ops: {pend[0], pend[1]}, aluc: pend[2]});
        pend.delete();
        nmodel++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic idle(input int n);
    nib_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_quiet();
    int w = 0;
    while ((busy || sbq.size() != 0) && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) chk("quiet_timeout", 32'(w), 32'd0);
  endtask

  // Monitor for the main instance.
  int         issued = 0, low_run = 0, cyc = 0, last_issue_cyc = -1;
  bit         prev_issue = 0;
  logic [7:0] last_ops = '0;
  logic [3:0] last_aluc = '0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      issued = 0; low_run = 0; prev_issue = 0;
      last_ops = '0; last_aluc = '0; last_issue_cyc = -1;
    end else begin
      chk("busy_not_ready", {31'd0, busy}, {31'd0, !nib_ready});
      chk("cmd_count", {24'd0, cmd_count}, 32'(issued % 256));
      if (issue) begin
        chk("issue_one_cycle", {31'd0, prev_issue}, 32'd0);
        if (sbq.size() == 0) begin
          chk("unexpected_issue", {24'd0, ops_out}, 32'hFFFF_FFFF);
        end else begin
          e = sbq.pop_front();
          chk("ops_out", {24'd0, ops_out}, {24'd0, e.ops});
          chk("aluc_out", {28'd0, aluc_out}, {28'd0, e.aluc});
        end
        if (contig && last_issue_cyc >= 0) chk("issue_period", 32'(cyc - last_issue_cyc), 32'd12);
        last_issue_cyc = contig ? cyc : -1;
        issued++;
        last_ops = ops_out;
        last_aluc = aluc_out;
      end else begin
        chk("ops_stable", {20'd0, ops_out, aluc_out}, {20'd0, last_ops, last_aluc});
      end
      if (nib_ready) begin
        if (low_run > 0) chk("ready_low_run", 32'(low_run), 32'd9);
        low_run = 0;
      end else begin
        low_run++;
      end
      prev_issue = issue;
    end
  end

  // Checker for the HOLD_CYCLES=0 instance: 4-cycle period, busy only in ISSUE.
  initial begin
    int last = -1, nper = 0;
    wait (rst_n === 1'b1);
    for (int c = 0; c < 60 && nper < 8; c++) begin
      @(negedge clk);
      chk("h0_busy_eq_issue", {31'd0, busy0}, {31'd0, issue0});
      if (issue0) begin
        if (last >= 0) begin
          chk("h0_period", 32'(c - last), 32'd4);
          nper++;
        end else begin
          chk("h0_first_cmd", {20'd0, ops0, aluc0}, 32'h999);
        end
        last = c;
      end
    end
    chk("h0_periods_seen", 32'(nper), 32'd8);
    done0 = 1;
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; nib_valid = 1'b0; nib_in = '0;
    #1;
    chk("rst_ops", {24'd0, ops_out}, 32'd0);
    chk("rst_aluc", {28'd0, aluc_out}, 32'd0);
    chk("rst_flags", {29'd0, issue, busy, nib_ready}, 32'd1);
    chk("rst_count", {24'd0, cmd_count}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Basic command.
    send(4'hA, 0); send(4'hB, 0); send(4'h2, 0);
    idle(3);
    chk("first_cmd_count", {24'd0, cmd_count}, 32'd1);
    wait_quiet();

    // Continuous valid: 12-cycle period.
    contig = 1;
    for (int i = 0; i < 9; i++) send(4'($urandom_range(0, 15)), 0);
    nib_valid = 1'b0;
    wait_quiet();
    contig = 0;

    // Stale partial load discarded by clr.
    send(4'h3, 0);
    idle(1);
    clr = 1'b1; @(posedge clk); @(negedge clk); clr = 1'b0;
    pend.delete();
    send(4'h5, 0); send(4'h6, 0); send(4'h1, 0);
    idle(1);
    wait_quiet();

    // clr colliding with the LOAD_C accept wins.
    send(4'hD, 0); send(4'hE, 0); send(4'hF, 1);
    idle(2);
    chk("clr_c_no_issue_ready", {31'd0, nib_ready}, 32'd1);

    wait (done0 == 1'b1);

    // Async reset mid-HOLD.
    send(4'hA, 0); send(4'hB, 0); send(4'hC, 0);
    idle(4);
    chk("in_hold", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ops", {24'd0, ops_out}, 32'd0);
    chk("arst_aluc", {28'd0, aluc_out}, 32'd0);
    chk("arst_flags", {29'd0, issue, busy, nib_ready}, 32'd1);
    chk("arst_count", {24'd0, cmd_count}, 32'd0);
    pend.delete(); sbq.delete(); nmodel = 0;
    nib_valid = 1'b1; nib_in = 4'hF;
    @(negedge clk); @(negedge clk);
    nib_valid = 1'b0;
    rst_n = 1'b1;
    send(4'h1, 0); send(4'h2, 0); send(4'h3, 0);
    idle(1);
    wait_quiet();
    chk("after_rst_count", {24'd0, cmd_count}, 32'd1);

    // Random traffic with bubbles and occasional clears.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send(4'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0));
    end
    nib_valid = 1'b0;
    wait_quiet();

    // Drive the counter through its wrap at 256 commands.
    pend.delete();
    for (int g = 0; g < 1000 && nmodel < 256; g++) send(4'($urandom_range(0, 15)), 0);
    nib_valid = 1'b0;
    wait_quiet();
    chk("wrap_total", 32'(nmodel), 32'd256);
    chk("cmd_count_wrap", {24'd0, cmd_count}, 32'd0);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
